// File: rtl/up_dn_counter_param_pkg.sv
// Shared definitions for the parametrised up/down counter.
package up_dn_counter_param_pkg;

    typedef enum logic [1:0] {
        MODE_SAT  = 2'b00,
        MODE_WRAP = 2'b01,
        MODE_PING = 2'b10,
        MODE_RSVD = 2'b11   // treated as saturate
    } mode_t;

endpackage

// File: rtl/up_dn_step_calc.sv
// Combinational step evaluation: given the current count, step size,
// direction and mode, produce the next count, boundary pulses and whether
// the ping-pong direction must reverse.
module up_dn_step_calc
    import up_dn_counter_param_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    input  logic             go_up,
    input  mode_t            mode,
    output logic [WIDTH-1:0] next_count,
    output logic             ovf,
    output logic             unf,
    output logic             flip_dir
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    // Headroom to each bound; count is always inside [MIN,MAX] so these
    // never go negative and comparing step against them cannot overflow.
    logic [WIDTH-1:0] room_up;
    logic [WIDTH-1:0] room_dn;
    logic             over_up;
    logic             over_dn;
    logic             land_up;
    logic             land_dn;

    assign room_up = MAX_W - count;
    assign room_dn = count - MIN_W;
    assign over_up = step > room_up;
    assign over_dn = step > room_dn;
    assign land_up = (step == room_up) && (step != '0);
    assign land_dn = (step == room_dn) && (step != '0);

    // Next-count selection per mode and direction
    always_comb begin
        next_count = count;
        ovf        = 1'b0;
        unf        = 1'b0;
        flip_dir   = 1'b0;
        if (go_up) begin
            if (over_up) begin
                ovf = 1'b1;
                case (mode)
                    MODE_WRAP: next_count = MIN_W + (step - room_up - ONE_W);
                    MODE_PING: begin
                        next_count = MAX_W;
                        flip_dir   = 1'b1;
                    end
                    default:   next_count = MAX_W;
                endcase
            end else begin
                next_count = count + step;
                flip_dir   = (mode == MODE_PING) && land_up;
            end
        end else begin
            if (over_dn) begin
                unf = 1'b1;
                case (mode)
                    MODE_WRAP: next_count = MAX_W - (step - room_dn - ONE_W);
                    MODE_PING: begin
                        next_count = MIN_W;
                        flip_dir   = 1'b1;
                    end
                    default:   next_count = MIN_W;
                endcase
            end else begin
                next_count = count - step;
                flip_dir   = (mode == MODE_PING) && land_dn;
            end
        end
    end

endmodule

// File: rtl/up_dn_counter_param.sv
// Parametrised up/down counter with saturate, wrap and ping-pong modes,
// registered boundary flags and one-cycle overflow/underflow pulses.
module up_dn_counter_param
    import up_dn_counter_param_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             UP,
    input  logic             DOWN,
    input  logic [WIDTH-1:0] STEP,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] COUNT,
    output logic             DIR,
    output logic             AT_MAX,
    output logic             AT_MIN,
    output logic             OVF,
    output logic             UNF
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    mode_t            mode;
    logic             ping;
    logic             go_up;
    logic             do_step;
    logic [WIDTH:0]   lo_diff;
    logic [WIDTH:0]   hi_diff;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] calc_next;
    logic             calc_ovf;
    logic             calc_unf;
    logic             calc_flip;

    logic [WIDTH-1:0] count_q;
    logic             dir_q;
    logic             at_max_q;
    logic             at_min_q;
    logic             ovf_q;
    logic             unf_q;

    assign mode = mode_t'(MODE);
    assign ping = (mode == MODE_PING);

    // Ping-pong ignores UP/DOWN and follows DIR; other modes need exactly one
    // of UP/DOWN to move.
    assign go_up   = ping ? dir_q : UP;
    assign do_step = EN && !LOAD && (ping || (UP ^ DOWN));

    // Clamp LOAD_VAL using the borrow bit of a widened subtraction, which
    // stays meaningful even when a bound sits at the edge of the WIDTH range.
    assign lo_diff = {1'b0, LOAD_VAL} - {1'b0, MIN_W};
    assign hi_diff = {1'b0, MAX_W} - {1'b0, LOAD_VAL};

    // Load clamp to [MIN_VAL, MAX_VAL]
    always_comb begin
        load_clamped = LOAD_VAL;
        if (lo_diff[WIDTH])      load_clamped = MIN_W;
        else if (hi_diff[WIDTH]) load_clamped = MAX_W;
    end

    up_dn_step_calc #(
        .WIDTH  (WIDTH),
        .MIN_VAL(MIN_VAL),
        .MAX_VAL(MAX_VAL)
    ) u_step (
        .count     (count_q),
        .step      (STEP),
        .go_up     (go_up),
        .mode      (mode),
        .next_count(calc_next),
        .ovf       (calc_ovf),
        .unf       (calc_unf),
        .flip_dir  (calc_flip)
    );

    // State update: reset > load > enabled step; pulses clear when idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q  <= MIN_W;
            dir_q    <= 1'b1;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (LOAD) begin
            count_q  <= load_clamped;
            at_max_q <= (load_clamped == MAX_W);
            at_min_q <= (load_clamped == MIN_W);
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (do_step) begin
            count_q  <= calc_next;
            at_max_q <= (calc_next == MAX_W);
            at_min_q <= (calc_next == MIN_W);
            ovf_q    <= calc_ovf;
            unf_q    <= calc_unf;
            if (calc_flip) dir_q <= ~dir_q;
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end
    end

    assign COUNT  = count_q;
    assign DIR    = dir_q;
    assign AT_MAX = at_max_q;
    assign AT_MIN = at_min_q;
    assign OVF    = ovf_q;
    assign UNF    = unf_q;

endmodule
